atm_multi_account_ctrl: RTL
===========================

// Module: atm_multi_account_ctrl
// PURPOSE
//  Parametrised next-generation ATM session controller: NUM_ACCOUNTS accounts, per-account PIN and balance,
//  wrong-PIN lockout, inactivity timeout and a multi-operation session loop.
//  Sits between the card/keypad front end and the display/dispenser; owns all balance state.
// PARAMETERS
//  NUM_ACCOUNTS  4      number of accounts (>=2); ACC_W = $clog2(NUM_ACCOUNTS)
//  PIN_W         4      PIN width in bits
//  BAL_W         16     balance/amount width, unsigned
//  INIT_BALANCE  500    balance of every account after reset
//  DEFAULT_PIN   4'hA   PIN of account k after reset = DEFAULT_PIN ^ k (truncated to PIN_W)
//  MAX_TRIES     3      consecutive wrong PINs that lock an account
//  TIMEOUT_CYC   1000   idle cycles in PIN_WAIT/MENU before forced eject
//  WD_LIMIT      200    per-session withdraw cap (ATM_SESSION_LIMIT_EN only)
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-low
//  card_in        in   1      level, card present
//  account_id     in   ACC_W  account on card, sampled IDLE->PIN_WAIT
//  pin            in   PIN_W  entered PIN, qualified by pin_valid
//  pin_valid      in   1      1-cycle strobe
//  op_valid       in   1      1-cycle strobe, qualifies op_code/amount in MENU
//  op_code        in   2      00 exit, 01 balance, 10 deposit, 11 withdraw
//  amount         in   BAL_W  deposit/withdraw amount
//  another_op     in   1      sampled in RESULT: 1 -> MENU, 0 -> EJECT
//  eject_card     in   1      user abort
//  correct_pin    out  1      level, high MENU..RESULT
//  card_locked    out  1      1-cycle pulse: locked account presented or lock just set
//  balance_out    out  BAL_W  balance of session account, valid with balance_valid
//  balance_valid  out  1      1-cycle pulse in RESULT for balance op
//  deposit_ok     out  1      1-cycle pulse in RESULT
//  withdraw_ok    out  1      1-cycle pulse in RESULT
//  op_error       out  1      1-cycle pulse in RESULT for rejected op
//  session_done   out  1      1-cycle pulse in EJECT
// BEHAVIOUR
//  Reset (reset=0): state IDLE, all outputs 0, balances=INIT_BALANCE, try counters 0, lock bits 0.
//  IDLE: card_in=1 -> latch account_id; lock bit set -> EJECT with card_locked pulse; else PIN_WAIT.
//  PIN_WAIT: pin_valid & match -> MENU, try cnt cleared. Mismatch -> cnt+1; cnt reaching MAX_TRIES -> lock bit, card_locked, EJECT.
//  MENU: op_valid -> EXEC with op/amount latched; op 00 -> EJECT directly.
//  EXEC (1 cycle): commit balance update; next cycle RESULT.
//    deposit: bal+amount > 2^BAL_W-1 -> reject, balance unchanged.
//    withdraw: amount>bal -> reject; amount==bal allowed -> 0.
//    amount==0 on deposit/withdraw -> reject.
//  RESULT (1 cycle): exactly one of balance_valid/deposit_ok/withdraw_ok/op_error pulses; balance_out = post-op balance.
//    Latency op_valid -> response pulse = 2 cycles.
//  EJECT (1 cycle): session_done, correct_pin=0, -> IDLE. IDLE stays until card_in seen 0 then 1 (no re-entry on held card).
//  Abort: card_in=0 or eject_card=1 in PIN_WAIT/MENU/RESULT -> EJECT next cycle; in EXEC commit completes first.
//  Timeout: counter counts in PIN_WAIT/MENU, clears on any strobe/state change; ==TIMEOUT_CYC-1 -> EJECT.
//  Simultaneous pin_valid and eject_card: eject wins, no try counted. Lock bits cleared only by reset.
// CONFIGURATION
//  ATM_SESSION_LIMIT_EN defined: session withdraw total tracked (clears in EJECT); withdraw pushing total > WD_LIMIT -> op_error, no change.
//  Undefined: no session accumulator, only the balance check applies.
// STRUCTURE
//  atm_pkg: state enum (IDLE, PIN_WAIT, MENU, EXEC, RESULT, EJECT), op_code constants OP_EXIT/OP_BAL/OP_DEP/OP_WD.
//  Sub-module atm_account_bank: balance+PIN+lock/try arrays, 1 read port, 1 write port (EXEC commit).
// TESTING
//  acct 2, pin 4'h8, balance op -> balance_valid, balance_out=500, 2 cycles after op_valid.
//  acct 1, deposit 40, another_op=1, withdraw 540 -> deposit_ok, then withdraw_ok, balance 0.
//  acct 0, wrong pin x3 -> card_locked, session_done; re-insert acct 0 -> card_locked immediately, no PIN_WAIT.
//  withdraw 501 on fresh account -> op_error, balance stays 500; deposit 65535 -> op_error.
//  MENU idle TIMEOUT_CYC cycles -> session_done; reset low mid-EXEC -> all balances 500.
//  ATM_SESSION_LIMIT_EN: withdraw 150 then 60 -> withdraw_ok then op_error, balance 350.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types for the ATM session controller: FSM states, result kinds and op codes.
package atm_pkg;

  typedef enum logic [2:0] {IDLE, PIN_WAIT, MENU, EXEC, RESULT, EJECT} state_e;

  typedef enum logic [1:0] {RES_BAL, RES_DEP, RES_WD, RES_ERR} result_e;

  localparam logic [1:0] OP_EXIT = 2'b00;
  localparam logic [1:0] OP_BAL  = 2'b01;
  localparam logic [1:0] OP_DEP  = 2'b10;
  localparam logic [1:0] OP_WD   = 2'b11;

endpackage

// File: rtl/atm_account_bank.sv
// Per-account storage: balances, wrong-PIN try counters and sticky lock bits.
// One shared read address for the session account, one balance write port.
module atm_account_bank
  import atm_pkg::*;
#(
  parameter int               NUM_ACCOUNTS = 4,
  parameter int               PIN_W        = 4,
  parameter int               BAL_W        = 16,
  parameter int               INIT_BALANCE = 500,
  parameter logic [PIN_W-1:0] DEFAULT_PIN  = 4'hA,
  parameter int               MAX_TRIES    = 3,
  localparam int              ACC_W        = $clog2(NUM_ACCOUNTS),
  localparam int              TRY_W        = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ACC_W-1:0] rd_acc,
  output logic [BAL_W-1:0] rd_bal,
  output logic [PIN_W-1:0] rd_pin,
  output logic             rd_locked,
  output logic             rd_last_try,
  input  logic             pin_fail,
  input  logic             pin_ok,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_acc,
  input  logic [BAL_W-1:0] wr_bal
);

  logic [BAL_W-1:0]        bal_q   [NUM_ACCOUNTS];
  logic [BAL_W-1:0]        bal_d   [NUM_ACCOUNTS];
  logic [TRY_W-1:0]        tries_q [NUM_ACCOUNTS];
  logic [TRY_W-1:0]        tries_d [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q, lock_d;

  // PINs are fixed per account, so they are derived rather than stored.
  assign rd_pin      = DEFAULT_PIN ^ PIN_W'(rd_acc);
  assign rd_bal      = bal_q[rd_acc];
  assign rd_locked   = lock_q[rd_acc];
  assign rd_last_try = (tries_q[rd_acc] == TRY_W'(MAX_TRIES - 1));

  always_comb begin
    bal_d   = bal_q;
    tries_d = tries_q;
    lock_d  = lock_q;
    if (pin_ok) begin
      tries_d[rd_acc] = '0;
    end else if (pin_fail) begin
      if (rd_last_try) begin
        lock_d[rd_acc]  = 1'b1;
        tries_d[rd_acc] = '0;
      end else begin
        tries_d[rd_acc] = tries_q[rd_acc] + 1'b1;
      end
    end
    if (wr_en) bal_d[wr_acc] = wr_bal;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_ACCOUNTS; k++) begin
        bal_q[k]   <= BAL_W'(INIT_BALANCE);
        tries_q[k] <= '0;
      end
      lock_q <= '0;
    end else begin
      bal_q   <= bal_d;
      tries_q <= tries_d;
      lock_q  <= lock_d;
    end
  end

endmodule

// File: rtl/atm_multi_account_ctrl.sv
// ATM session controller: card/PIN handshake, operation loop, timeout and bank commit.
// Define ATM_SESSION_LIMIT_EN to cap the total withdrawn per session at WD_LIMIT.
module atm_multi_account_ctrl
  import atm_pkg::*;
#(
`ifdef ATM_SESSION_LIMIT_EN
  parameter int               WD_LIMIT     = 200,
`endif
  parameter int               NUM_ACCOUNTS = 4,
  parameter int               PIN_W        = 4,
  parameter int               BAL_W        = 16,
  parameter int               INIT_BALANCE = 500,
  parameter logic [PIN_W-1:0] DEFAULT_PIN  = 4'hA,
  parameter int               MAX_TRIES    = 3,
  parameter int               TIMEOUT_CYC  = 1000,
  localparam int              ACC_W        = $clog2(NUM_ACCOUNTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             card_in,
  input  logic [ACC_W-1:0] account_id,
  input  logic [PIN_W-1:0] pin,
  input  logic             pin_valid,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [BAL_W-1:0] amount,
  input  logic             another_op,
  input  logic             eject_card,
  output logic             correct_pin,
  output logic             card_locked,
  output logic [BAL_W-1:0] balance_out,
  output logic             balance_valid,
  output logic             deposit_ok,
  output logic             withdraw_ok,
  output logic             op_error,
  output logic             session_done
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  state_e           state_q, state_d;
  result_e          res_q, res_d;
  logic [ACC_W-1:0] acc_q, acc_d, rd_acc;
  logic [1:0]       op_q, op_d;
  logic [BAL_W-1:0] amt_q, amt_d, res_bal_q, res_bal_d, bank_bal, wr_bal;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [PIN_W-1:0] bank_pin;
  logic [BAL_W:0]   dep_sum;
  logic             armed_q, armed_d, card_locked_q, card_locked_d;
  logic             bank_locked, bank_last_try, pin_fail, pin_ok, wr_en;
  logic             abort, timeout, wd_ok, in_result;

  // IDLE looks up the account on the card; afterwards the latched session account is used.
  assign rd_acc  = (state_q == IDLE) ? account_id : acc_q;
  assign abort   = !card_in || eject_card;
  assign timeout = (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
  assign dep_sum = {1'b0, bank_bal} + {1'b0, amt_q};

  atm_account_bank #(
    .NUM_ACCOUNTS(NUM_ACCOUNTS), .PIN_W(PIN_W), .BAL_W(BAL_W),
    .INIT_BALANCE(INIT_BALANCE), .DEFAULT_PIN(DEFAULT_PIN), .MAX_TRIES(MAX_TRIES)
  ) u_bank (
    .clk(clk), .reset(reset), .rd_acc(rd_acc), .rd_bal(bank_bal), .rd_pin(bank_pin),
    .rd_locked(bank_locked), .rd_last_try(bank_last_try), .pin_fail(pin_fail),
    .pin_ok(pin_ok), .wr_en(wr_en), .wr_acc(acc_q), .wr_bal(wr_bal)
  );

`ifdef ATM_SESSION_LIMIT_EN
  logic [BAL_W-1:0] wd_total_q, wd_total_d;
  logic [BAL_W:0]   wd_sum;

  assign wd_sum = {1'b0, wd_total_q} + {1'b0, amt_q};
  assign wd_ok  = (wd_sum <= (BAL_W + 1)'(WD_LIMIT));

  always_comb begin
    wd_total_d = wd_total_q;
    if (state_q == EJECT) wd_total_d = '0;
    else if (state_q == EXEC && op_q == OP_WD && wr_en) wd_total_d = wd_sum[BAL_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wd_total_q <= '0;
    else        wd_total_q <= wd_total_d;
  end
`else
  assign wd_ok = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    op_d          = op_q;
    amt_d         = amt_q;
    res_d         = res_q;
    res_bal_d     = res_bal_q;
    armed_d       = armed_q;
    card_locked_d = 1'b0;
    pin_fail      = 1'b0;
    pin_ok        = 1'b0;
    wr_en         = 1'b0;
    wr_bal        = bank_bal;
    // A held card must be pulled out before another session may begin.
    if (!card_in) armed_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (card_in && armed_q) begin
          armed_d = 1'b0;
          acc_d   = account_id;
          if (bank_locked) begin
            card_locked_d = 1'b1;
            state_d       = EJECT;
          end else begin
            state_d = PIN_WAIT;
          end
        end
      end
      PIN_WAIT: begin
        if (abort) begin
          state_d = EJECT;
        end else if (pin_valid) begin
          if (pin == bank_pin) begin
            pin_ok  = 1'b1;
            state_d = MENU;
          end else begin
            pin_fail = 1'b1;
            if (bank_last_try) begin
              card_locked_d = 1'b1;
              state_d       = EJECT;
            end
          end
        end else if (timeout) begin
          state_d = EJECT;
        end
      end
      MENU: begin
        if (abort) begin
          state_d = EJECT;
        end else if (op_valid) begin
          if (op_code == OP_EXIT) begin
            state_d = EJECT;
          end else begin
            op_d    = op_code;
            amt_d   = amount;
            state_d = EXEC;
          end
        end else if (timeout) begin
          state_d = EJECT;
        end
      end
      EXEC: begin
        state_d = RESULT;
        res_d   = RES_ERR;
        case (op_q)
          OP_BAL: res_d = RES_BAL;
          OP_DEP: begin
            if (amt_q != '0 && !dep_sum[BAL_W]) begin
              res_d  = RES_DEP;
              wr_en  = 1'b1;
              wr_bal = dep_sum[BAL_W-1:0];
            end
          end
          OP_WD: begin
            if (amt_q != '0 && amt_q <= bank_bal && wd_ok) begin
              res_d  = RES_WD;
              wr_en  = 1'b1;
              wr_bal = bank_bal - amt_q;
            end
          end
          default: res_d = RES_ERR;
        endcase
        res_bal_d = wr_bal;
      end
      RESULT:  state_d = (abort || !another_op) ? EJECT : MENU;
      EJECT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Idle timer only runs while waiting on the user and restarts on any strobe or state change.
  always_comb begin
    tmr_d = '0;
    if ((state_q == PIN_WAIT || state_q == MENU) && state_d == state_q && !pin_valid && !op_valid)
      tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      op_q          <= OP_EXIT;
      amt_q         <= '0;
      res_q         <= RES_BAL;
      res_bal_q     <= '0;
      tmr_q         <= '0;
      armed_q       <= 1'b0;
      card_locked_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      op_q          <= op_d;
      amt_q         <= amt_d;
      res_q         <= res_d;
      res_bal_q     <= res_bal_d;
      tmr_q         <= tmr_d;
      armed_q       <= armed_d;
      card_locked_q <= card_locked_d;
    end
  end

  assign in_result     = (state_q == RESULT);
  assign correct_pin   = (state_q == MENU) || (state_q == EXEC) || in_result;
  assign card_locked   = card_locked_q;
  assign session_done  = (state_q == EJECT);
  assign balance_out   = in_result ? res_bal_q : '0;
  assign balance_valid = in_result && (res_q == RES_BAL);
  assign deposit_ok    = in_result && (res_q == RES_DEP);
  assign withdraw_ok   = in_result && (res_q == RES_WD);
  assign op_error      = in_result && (res_q == RES_ERR);

endmodule
